// File: rtl/muldiv_sequencer.sv
// Iterative MUL/DIV/REM unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: trivial cases (zero operand, divide by zero, overflow) finish from PREP.
module muldiv_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [3:0]      OP_MUL  = 4'b1001;
   localparam logic [3:0]      OP_DIV  = 4'b1010;
   localparam logic [3:0]      OP_REM  = 4'b1011;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_op;
   logic [XLEN-1:0]   r_rs1;
   logic [XLEN-1:0]   r_rs2;
   logic [XLEN-1:0]   r_bmag;
   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_result;
   logic [2*XLEN-1:0] r_prod;
   logic              r_neg_a;
   logic              r_neg_b;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_op_valid;
   logic              w_accept;
   logic              w_last;
   logic              w_special;
   logic [XLEN-1:0]   w_special_val;
   logic [XLEN-1:0]   w_final;
   logic [XLEN-1:0]   w_abs1;
   logic [XLEN-1:0]   w_abs2;
   logic [XLEN-1:0]   w_rem_next;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shift;
   logic [XLEN:0]     w_diff;

   assign w_op_valid = (op_i == OP_MUL) || (op_i == OP_DIV) || (op_i == OP_REM);
   assign w_accept   = start_i && w_op_valid && !flush_i &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last     = (r_cnt == CNT_W'(XLEN - 1));
   assign w_abs1     = r_rs1[XLEN-1] ? -r_rs1 : r_rs1;
   assign w_abs2     = r_rs2[XLEN-1] ? -r_rs2 : r_rs2;

   // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
   assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_bmag} : '0);

   // Restoring divide: w_shift is the XLEN+1-bit partial remainder; a set sign bit means restore.
   assign w_shift    = {r_rem, r_quo[XLEN-1]};
   assign w_diff     = w_shift - {1'b0, r_bmag};
   assign w_rem_next = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];

   always_comb begin
      w_special     = 1'b0;
      w_special_val = '0;
      case (r_op)
         OP_MUL: w_special = (r_rs1 == '0) || (r_rs2 == '0);
         OP_DIV: begin
            if (r_rs2 == '0) begin
               w_special     = 1'b1;
               w_special_val = '1;
            end else if ((r_rs1 == MIN_NEG) && (r_rs2 == '1)) begin
               w_special     = 1'b1;
               w_special_val = MIN_NEG;
            end
         end
         OP_REM: begin
            if (r_rs2 == '0) begin
               w_special     = 1'b1;
               w_special_val = r_rs1;
            end else if ((r_rs1 == MIN_NEG) && (r_rs2 == '1)) begin
               w_special     = 1'b1;
               w_special_val = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_final = '0;
      if (w_special) begin
         w_final = w_special_val;
      end else begin
         case (r_op)
            OP_MUL:  w_final = (r_neg_a ^ r_neg_b) ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
            OP_DIV:  w_final = (r_neg_a ^ r_neg_b) ? -r_quo : r_quo;
            OP_REM:  w_final = r_neg_a ? -r_rem : r_rem;
            default: w_final = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_PREP;
         S_PREP: begin
`ifdef MULDIV_EARLY_OUT_EN
            w_next = w_special ? S_DONE : S_CALC;
`else
            w_next = S_CALC;
`endif
         end
         S_CALC:  if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = w_accept ? S_PREP : S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush_i) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_bmag   <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_prod   <= '0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_op  <= op_i;
            r_rs1 <= rs1_i;
            r_rs2 <= rs2_i;
         end
         case (r_state)
            S_PREP: begin
               r_neg_a <= r_rs1[XLEN-1];
               r_neg_b <= r_rs2[XLEN-1];
               r_cnt   <= '0;
               r_rem   <= '0;
               if (r_op == OP_MUL) begin
                  r_bmag <= w_abs1;
                  r_prod <= {{XLEN{1'b0}}, w_abs2};
               end else begin
                  r_bmag <= w_abs2;
                  r_quo  <= w_abs1;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_op == OP_MUL) begin
                  r_prod <= {w_sum, r_prod[XLEN-1:1]};
               end else begin
                  r_rem <= w_rem_next;
                  r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
               end
            end
            default: ;
         endcase
         // A flush redirects w_next to IDLE, so an aborted op never reaches result_o.
         if ((r_state != S_DONE) && (w_next == S_DONE)) r_result <= w_final;
      end
   end

   assign busy_o   = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
   assign done_o   = (r_state == S_DONE);
   assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus random ops against a plain-arithmetic model.
// Expected done timing follows MULDIV_EARLY_OUT_EN when it is defined for the build.
module tb_muldiv_sequencer;

   localparam int          XLEN    = 32;
   localparam logic [3:0]  OP_MUL  = 4'b1001;
   localparam logic [3:0]  OP_DIV  = 4'b1010;
   localparam logic [3:0]  OP_REM  = 4'b1011;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [3:0]  op_i    = 4'h0;
   logic [31:0] rs1_i   = 32'h0;
   logic [31:0] rs2_i   = 32'h0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t        sbQ[$];
   exp_t        monE;
   exp_t        dropped;
   int          total   = 0;
   int          bad     = 0;
   int          cyc     = 0;
   logic [31:0] lastExp = 32'h0;

   muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: signed arithmetic on 64-bit values, truncated to XLEN bits.
   function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sA;
      longint sB;
      sA = longint'($signed(a));
      sB = longint'($signed(b));
      case (op)
         OP_MUL: return 32'(sA * sB);
         OP_DIV: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            return 32'(sA / sB);
         end
         OP_REM: begin
            if (b == 32'h0) return a;
            return 32'(sA % sB);
         end
         default: return 32'h0;
      endcase
   endfunction

   function automatic int expLatency(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bit trivial;
      bit early;
      trivial = (op == OP_MUL) ? ((a == 32'h0) || (b == 32'h0))
                               : ((b == 32'h0) || ((a == MIN_NEG) && (b == 32'hFFFF_FFFF)));
      early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early = 1'b1;
`endif
      return (trivial && early) ? 2 : XLEN + 3;
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return MIN_NEG;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'(int'($urandom_range(0, 40)) - 20);
         default: return $urandom();
      endcase
   endfunction

   // Monitor: every done_o pops one expectation; an overdue expectation is reported and dropped.
   always @(negedge clk) begin
      if (done_o) begin
         if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done: got result 0x%08h with nothing outstanding (cycle %0d)",
                     result_o, cyc);
         end else begin
            monE = sbQ.pop_front();
            checkOutput("result", result_o, monE.res);
            checkOutput("done_cycle", 32'(cyc), 32'(monE.due));
            lastExp = monE.res;
         end
      end else if ((sbQ.size() > 0) && (cyc > sbQ[0].due)) begin
         monE = sbQ.pop_front();
         total++;
         bad++;
         $display("[TB] FAIL missing_done: no done_o by cycle %0d, required at cycle %0d", cyc, monE.due);
      end
   end

   // Drives a start for one cycle from the current point; caller must be at a negedge.
   task automatic issueOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expRes);
      exp_t e;
      start_i = 1'b1;
      op_i    = op;
      rs1_i   = a;
      rs2_i   = b;
      e.res   = expRes;
      e.due   = cyc + expLatency(op, a, b);
      sbQ.push_back(e);
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Returns at the negedge in which done_o is seen (the DONE cycle), counting busy cycles on the way.
   task automatic waitDone(input int lat);
      int busyCnt;
      int guard;
      busyCnt = 0;
      guard   = 0;
      while (!done_o && (guard < 200)) begin
         if (busy_o) busyCnt++;
         @(negedge clk);
         guard++;
      end
      checkOutput("busy_cycles", 32'(busyCnt), 32'(lat - 1));
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expRes);
      @(negedge clk);
      issueOp(op, a, b, expRes);
      waitDone(expLatency(op, a, b));
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0]  rOp;
      logic [31:0] rA;
      logic [31:0] rB;

      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy", {31'h0, busy_o}, 32'h0);
      checkOutput("reset_done", {31'h0, done_o}, 32'h0);
      checkOutput("reset_result", result_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6);
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      applyStimulus(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001);
      applyStimulus(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
      applyStimulus(OP_REM, 32'd5, 32'd0, 32'd5);
      applyStimulus(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
      applyStimulus(OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
      applyStimulus(OP_DIV, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG);
      applyStimulus(OP_REM, MIN_NEG, 32'hFFFF_FFFF, 32'h0);
      applyStimulus(OP_MUL, 32'd0, 32'd1234, 32'h0);
      applyStimulus(OP_MUL, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG);
      applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
      applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd14);

      // Flush ten cycles into a DIV; the next start, one cycle later, must complete normally.
      @(negedge clk);
      issueOp(OP_DIV, 32'd1000, 32'd7, 32'd142);
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      dropped = sbQ.pop_back();
      @(negedge clk);
      flush_i = 1'b0;
      checkOutput("flush_busy", {31'h0, busy_o}, 32'h0);
      checkOutput("flush_result", result_o, lastExp);
      issueOp(OP_MUL, 32'd12345, 32'd678, 32'd8369910);
      waitDone(expLatency(OP_MUL, 32'd12345, 32'd678));

      // Back-to-back: the second op is issued in the DONE cycle of the first.
      @(negedge clk);
      issueOp(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
      waitDone(XLEN + 3);
      issueOp(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
      waitDone(XLEN + 3);

      // A start (with new operands) while busy is ignored.
      @(negedge clk);
      issueOp(OP_MUL, 32'd3, 32'd5, 32'd15);
      repeat (4) @(negedge clk);
      start_i = 1'b1;
      op_i    = OP_DIV;
      rs1_i   = 32'd99;
      rs2_i   = 32'd3;
      @(negedge clk);
      start_i = 1'b0;
      waitDone(XLEN + 3 - 5);

      // Invalid op, and flush colliding with a valid start, both leave the unit idle.
      @(negedge clk);
      start_i = 1'b1;
      op_i    = 4'b0000;
      @(negedge clk);
      start_i = 1'b0;
      checkOutput("invalid_op_busy", {31'h0, busy_o}, 32'h0);
      start_i = 1'b1;
      flush_i = 1'b1;
      op_i    = OP_MUL;
      rs1_i   = 32'd9;
      rs2_i   = 32'd9;
      @(negedge clk);
      start_i = 1'b0;
      flush_i = 1'b0;
      checkOutput("flush_start_busy", {31'h0, busy_o}, 32'h0);
      repeat (40) @(negedge clk);

      // Asynchronous reset twenty cycles into a MUL.
      @(negedge clk);
      issueOp(OP_MUL, 32'd1001, 32'd77, 32'd77077);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      sbQ.delete();
      #1;
      checkOutput("async_reset_busy", {31'h0, busy_o}, 32'h0);
      checkOutput("async_reset_done", {31'h0, done_o}, 32'h0);
      checkOutput("async_reset_result", result_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (45) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0:       rOp = OP_MUL;
            1:       rOp = OP_DIV;
            default: rOp = OP_REM;
         endcase
         rA = pickOperand();
         rB = pickOperand();
         applyStimulus(rOp, rA, rB, refModel(rOp, rA, rB));
      end

      repeat (50) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
